logic_and_or_not_ctrl: RTL and testbench

Clocked start/stop decision logic for the magnetron controller. Samples the front-panel commands (start, stop, clear), the door interlock and the cooking-timer flag, and produces the set and reset commands for the magnetron latch. Also holds a registered magnetron-on state. Sits between the keypad/interlock inputs and the magnetron driver stage.

---
 rtl/logic_and_or_not_ctrl.sv | 91 +++++++++
 tb/tb_logic_and_or_not_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/logic_and_or_not_ctrl.sv
// Start/stop decision logic for the magnetron latch: synchronizes panel and
// interlock inputs and registers set/reset commands plus the magnetron state.
module logic_and_or_not_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic clear,
  input  logic door_closed,
  input  logic timer_done,
  output logic set,
  output logic reset,
  output logic mag_on
);

  localparam int unsigned NUM_IN  = 5;
  localparam int unsigned IDX_STA = 0;
  localparam int unsigned IDX_STO = 1;
  localparam int unsigned IDX_CLR = 2;
  localparam int unsigned IDX_DOR = 3;
  localparam int unsigned IDX_TMR = 4;

  logic [NUM_IN-1:0] raw_in;
  logic [NUM_IN-1:0] sync_q [SYNC_STAGES];

  logic s_start;
  logic s_stop;
  logic s_clear;
  logic s_door;
  logic s_timer;

  logic kill;
  logic set_nxt;
  logic reset_nxt;
  logic mag_on_nxt;

  assign raw_in = {timer_done, door_closed, clear, stop, start};

  // Per-input synchronizer chain; clearing it makes the door read as open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_start = sync_q[SYNC_STAGES-1][IDX_STA];
  assign s_stop  = sync_q[SYNC_STAGES-1][IDX_STO];
  assign s_clear = sync_q[SYNC_STAGES-1][IDX_CLR];
  assign s_door  = sync_q[SYNC_STAGES-1][IDX_DOR];
  assign s_timer = sync_q[SYNC_STAGES-1][IDX_TMR];

  // Any kill condition overrides start, so set and reset never coincide.
  always_comb begin
    kill       = 1'b0;
    set_nxt    = 1'b0;
    reset_nxt  = 1'b0;
    mag_on_nxt = mag_on;

    kill      = s_stop | s_clear | s_timer | ~s_door;
    set_nxt   = s_start & ~kill;
    reset_nxt = kill;

    if (reset_nxt) begin
      mag_on_nxt = 1'b0;
    end else if (set_nxt) begin
      mag_on_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set    <= 1'b0;
      reset  <= 1'b0;
      mag_on <= 1'b0;
    end else begin
      set    <= set_nxt;
      reset  <= reset_nxt;
      mag_on <= mag_on_nxt;
    end
  end

endmodule

// File: tb/tb_logic_and_or_not_ctrl.sv
// Directed-vector bench for logic_and_or_not_ctrl; expected {set,reset,mag_on}
// values are hand-computed from the decision equations and the 3-edge latency.
module tb_logic_and_or_not_ctrl;

  logic clk;
  logic rst_n;
  logic start;
  logic stop;
  logic clear;
  logic door_closed;
  logic timer_done;
  logic set;
  logic reset;
  logic mag_on;

  int unsigned n_vec;
  int unsigned n_miss;

  logic [2:0] outs;
  assign outs = {set, reset, mag_on};

  logic_and_or_not_ctrl #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .set         (set),
    .reset       (reset),
    .mag_on      (mag_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got {set,reset,mag_on}=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic cl,
                       input logic dr, input logic tm);
    start       = st;
    stop        = sp;
    clear       = cl;
    door_closed = dr;
    timer_done  = tm;
  endtask

  // Hold one stimulus for 5 cycles, then compare against the settled value.
  task automatic step(input string tag, input logic st, input logic sp, input logic cl,
                      input logic dr, input logic tm, input logic [2:0] exp);
    drive(st, sp, cl, dr, tm);
    repeat (5) @(negedge clk);
    chk(tag, outs, exp);
  endtask

  // set and reset must never be high together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("excl", {2'b00, set & reset}, 3'b000);
    end
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Power-up: door reads open until synchronized.
    repeat (3) @(negedge clk);
    chk("rst_hold", outs, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pwr_edge1", outs, 3'b010);
    @(negedge clk);
    chk("pwr_edge2", outs, 3'b010);
    @(negedge clk);
    chk("pwr_edge3", outs, 3'b000);
    repeat (3) @(negedge clk);
    chk("pwr_idle", outs, 3'b000);

    // Start latency: new value on the third edge after sampling.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_edge1", outs, 3'b000);
    @(negedge clk);
    chk("lat_edge2", outs, 3'b000);
    @(negedge clk);
    chk("lat_edge3", outs, 3'b101);
    repeat (2) @(negedge clk);
    chk("start_hold", outs, 3'b101);

    step("start_rel",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
    step("door_open_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    step("door_open_idle",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    step("door_close_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
    step("restart1",        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101);
    step("stop",            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
    step("restart2",        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101);
    step("clear",           1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010);
    step("start_clear",     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010);
    step("restart3",        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101);
    step("timer",           1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010);
    step("start_timer",     1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010);
    step("restart4",        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101);
    step("start_stop",      1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
    step("restart5",        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101);
    step("hold_on",         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);

    // Asynchronous reset mid-cycle while the magnetron is on.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", outs, 3'b000);
    @(negedge clk);
    chk("async_rst_hold", outs, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerel_edge1", outs, 3'b010);
    repeat (4) @(negedge clk);
    chk("rerel_idle", outs, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
